// File: rtl/l15_rtrn_stub.sv
// L1.5 request/return responder backed by a small word memory, for standalone cache simulation.
// Optional L15_RTRN_ALIGN_CHK_EN: misaligned STORE/ATOMIC requests return L15_ERR_RET without writing.
module l15_rtrn_stub #(
    parameter int MEM_DEPTH      = 64,
    parameter int REQ_FIFO_DEPTH = 2,
    parameter int LATENCY        = 2,
    parameter int TID_WIDTH      = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_val_i,
    output logic                 req_rdy_o,
    input  logic [4:0]           req_rqtype_i,
    input  logic [TID_WIDTH-1:0] req_tid_i,
    input  logic [39:0]          req_addr_i,
    input  logic [1:0]           req_size_i,
    input  logic [63:0]          req_data_i,
    output logic                 rtrn_val_o,
    input  logic                 rtrn_ack_i,
    output logic [3:0]           rtrn_type_o,
    output logic [TID_WIDTH-1:0] rtrn_tid_o,
    output logic [63:0]          rtrn_data_o,
    output logic                 busy_o
);

    // Encodings match wt_cache_pkg l15_reqtypes_t / l15_rtrntypes_t.
    localparam logic [4:0] L15_LOAD_RQ   = 5'b00000;
    localparam logic [4:0] L15_IMISS_RQ  = 5'b10000;
    localparam logic [4:0] L15_STORE_RQ  = 5'b00001;
    localparam logic [4:0] L15_ATOMIC_RQ = 5'b00110;
    localparam logic [4:0] L15_INT_RQ    = 5'b01001;

    localparam logic [3:0] L15_LOAD_RET               = 4'b0000;
    localparam logic [3:0] L15_IFILL_RET              = 4'b0001;
    localparam logic [3:0] L15_ST_ACK                 = 4'b0100;
    localparam logic [3:0] L15_INT_RET                = 4'b0111;
    localparam logic [3:0] L15_ERR_RET                = 4'b1100;
    localparam logic [3:0] L15_CPX_RESTYPE_ATOMIC_RES = 4'b1110;

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int PTR_W = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(REQ_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [4:0]           rqtype;
        logic [TID_WIDTH-1:0] tid;
        logic [39:0]          addr;
        logic [1:0]           size;
        logic [63:0]          data;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    req_t             fifo_mem [REQ_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             exec;

    state_t           state;
    state_t           state_next;
    req_t             cur;
    logic [7:0]       cnt;

    logic [63:0]      mem [MEM_DEPTH];
    logic [IDX_W-1:0] word_idx;
    logic [63:0]      old_word;
    logic [63:0]      byte_mask;
    logic [3:0]       byte_end;
    logic             mem_we;
    logic [3:0]       ex_type;
    logic [63:0]      ex_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(REQ_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full  = (fifo_cnt == CNT_W'(REQ_FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign req_rdy_o  = !fifo_full && !rst_i;
    assign push       = req_val_i && req_rdy_o;
    assign busy_o     = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{rqtype: req_rqtype_i, tid: req_tid_i, addr: req_addr_i,
                                  size: req_size_i, data: req_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        exec       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 8'd0) begin
                    exec       = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rtrn_ack_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte lanes touched by a store: [offset, offset + size) clipped at the end of the word.
    always_comb begin
        word_idx  = cur.addr[3 +: IDX_W];
        old_word  = mem[word_idx];
        byte_end  = {1'b0, cur.addr[2:0]} + (4'd1 << cur.size);
        byte_mask = '0;
        for (int k = 0; k < 8; k++) begin
            if ((4'(k) >= {1'b0, cur.addr[2:0]}) && (4'(k) < byte_end)) begin
                byte_mask[8*k +: 8] = 8'hFF;
            end
        end

        mem_we  = 1'b0;
        ex_type = L15_ERR_RET;
        ex_data = '0;
        case (cur.rqtype)
            L15_LOAD_RQ: begin
                ex_type = L15_LOAD_RET;
                ex_data = old_word;
            end
            L15_IMISS_RQ: begin
                ex_type = L15_IFILL_RET;
                ex_data = old_word;
            end
            L15_STORE_RQ: begin
                ex_type = L15_ST_ACK;
                mem_we  = 1'b1;
            end
            L15_ATOMIC_RQ: begin
                ex_type = L15_CPX_RESTYPE_ATOMIC_RES;
                ex_data = old_word;
                mem_we  = 1'b1;
            end
            L15_INT_RQ: begin
                ex_type = L15_INT_RET;
                ex_data = {24'h0, cur.addr};
            end
            default: ;
        endcase
`ifdef L15_RTRN_ALIGN_CHK_EN
        if (((cur.rqtype == L15_STORE_RQ) || (cur.rqtype == L15_ATOMIC_RQ)) &&
            (((cur.size == 2'd1) && (cur.addr[0] != 1'b0)) ||
             ((cur.size == 2'd2) && (cur.addr[1:0] != 2'b00)) ||
             ((cur.size == 2'd3) && (cur.addr[2:0] != 3'b000)))) begin
            mem_we  = 1'b0;
            ex_type = L15_ERR_RET;
            ex_data = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (exec && mem_we) begin
            mem[word_idx] <= (old_word & ~byte_mask) | (cur.data & byte_mask);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur         <= '0;
            cnt         <= '0;
            rtrn_val_o  <= 1'b0;
            rtrn_type_o <= '0;
            rtrn_tid_o  <= '0;
            rtrn_data_o <= '0;
        end else begin
            if (pop) begin
                cur <= fifo_mem[rd_ptr];
                cnt <= 8'(LATENCY);
            end else if ((state == WAIT) && (cnt != 8'd0)) begin
                cnt <= cnt - 8'd1;
            end

            if (exec) begin
                rtrn_val_o  <= 1'b1;
                rtrn_type_o <= ex_type;
                rtrn_tid_o  <= cur.tid;
                rtrn_data_o <= ex_data;
            end else if ((state == RESP) && rtrn_ack_i) begin
                rtrn_val_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_l15_rtrn_stub.sv
// Scoreboard bench for l15_rtrn_stub: directed requests queue their expected returns, a monitor checks them.
module tb_l15_rtrn_stub;

    localparam int LAT  = 2;
    localparam int TIDW = 4;

    localparam logic [4:0] RQ_LOAD   = 5'b00000;
    localparam logic [4:0] RQ_IMISS  = 5'b10000;
    localparam logic [4:0] RQ_STORE  = 5'b00001;
    localparam logic [4:0] RQ_ATOMIC = 5'b00110;
    localparam logic [4:0] RQ_INT    = 5'b01001;
    localparam logic [4:0] RQ_RSVD   = 5'b11111;

    localparam logic [3:0] RT_LOAD   = 4'b0000;
    localparam logic [3:0] RT_IFILL  = 4'b0001;
    localparam logic [3:0] RT_ST_ACK = 4'b0100;
    localparam logic [3:0] RT_INT    = 4'b0111;
    localparam logic [3:0] RT_ERR    = 4'b1100;
    localparam logic [3:0] RT_ATOMIC = 4'b1110;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_val_i = 1'b0;
    logic            req_rdy_o;
    logic [4:0]      req_rqtype_i = '0;
    logic [TIDW-1:0] req_tid_i = '0;
    logic [39:0]     req_addr_i = '0;
    logic [1:0]      req_size_i = '0;
    logic [63:0]     req_data_i = '0;
    logic            rtrn_val_o;
    logic            rtrn_ack_i = 1'b1;
    logic [3:0]      rtrn_type_o;
    logic [TIDW-1:0] rtrn_tid_o;
    logic [63:0]     rtrn_data_o;
    logic            busy_o;

    typedef struct {
        logic [3:0]      rtype;
        logic [TIDW-1:0] tid;
        logic [63:0]     data;
        int              exp_cycle;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cycle  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    l15_rtrn_stub #(
        .MEM_DEPTH(64),
        .REQ_FIFO_DEPTH(2),
        .LATENCY(LAT),
        .TID_WIDTH(TIDW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .req_val_i(req_val_i),
        .req_rdy_o(req_rdy_o),
        .req_rqtype_i(req_rqtype_i),
        .req_tid_i(req_tid_i),
        .req_addr_i(req_addr_i),
        .req_size_i(req_size_i),
        .req_data_i(req_data_i),
        .rtrn_val_o(rtrn_val_o),
        .rtrn_ack_i(rtrn_ack_i),
        .rtrn_type_o(rtrn_type_o),
        .rtrn_tid_o(rtrn_tid_o),
        .rtrn_data_o(rtrn_data_o),
        .busy_o(busy_o)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Drives one request starting at posedge+1; returns at posedge+1 after the push edge.
    task automatic applyStimulus(input logic [4:0] rq, input logic [TIDW-1:0] tid,
                                 input logic [39:0] addr, input logic [1:0] size,
                                 input logic [63:0] data, input logic [3:0] exp_type,
                                 input logic [63:0] exp_data, input bit expect_rsp,
                                 input bit chk_lat);
        int   waited;
        exp_t e;
        waited       = 0;
        req_val_i    = 1'b1;
        req_rqtype_i = rq;
        req_tid_i    = tid;
        req_addr_i   = addr;
        req_size_i   = size;
        req_data_i   = data;
        @(negedge clk);
        while (!req_rdy_o && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!req_rdy_o) begin
            checkOutput("req_rdy_timeout", 64'(req_rdy_o), 64'd1);
            req_val_i = 1'b0;
            return;
        end
        if (expect_rsp) begin
            e.rtype     = exp_type;
            e.tid       = tid;
            e.data      = exp_data;
            e.exp_cycle = chk_lat ? (cycle + 3 + LAT) : -1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_val_i = 1'b0;
    endtask

    task automatic waitIdle();
        int waited;
        waited = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy_o) && waited < 500) begin
            waited++;
            @(negedge clk);
        end
        if (sb.size() != 0 || busy_o) begin
            checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks each new packet against the scoreboard and that held packets stay stable.
    initial begin : monitor
        logic            prev_val;
        logic            prev_ack;
        logic [3:0]      prev_type;
        logic [TIDW-1:0] prev_tid;
        logic [63:0]     prev_data;
        exp_t            e;
        prev_val  = 1'b0;
        prev_ack  = 1'b0;
        prev_type = '0;
        prev_tid  = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_val = 1'b0;
            end else begin
                if (rtrn_val_o && (!prev_val || prev_ack)) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_packet_tid", 64'(rtrn_tid_o), 64'hFFFF);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("rtrn_type", 64'(rtrn_type_o), 64'(e.rtype));
                        checkOutput("rtrn_tid", 64'(rtrn_tid_o), 64'(e.tid));
                        checkOutput("rtrn_data", rtrn_data_o, e.data);
                        if (e.exp_cycle >= 0) begin
                            checkOutput("latency_cycle", 64'(cycle), 64'(e.exp_cycle));
                        end
                    end
                end else if (rtrn_val_o) begin
                    checkOutput("hold_type", 64'(rtrn_type_o), 64'(prev_type));
                    checkOutput("hold_tid", 64'(rtrn_tid_o), 64'(prev_tid));
                    checkOutput("hold_data", rtrn_data_o, prev_data);
                end
                prev_val = rtrn_val_o;
            end
            prev_ack  = rtrn_ack_i;
            prev_type = rtrn_type_o;
            prev_tid  = rtrn_tid_o;
            prev_data = rtrn_data_o;
        end
    end

    initial begin : stimulus
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdy", 64'(req_rdy_o), 64'd0);
        checkOutput("reset_val", 64'(rtrn_val_o), 64'd0);
        checkOutput("reset_type", 64'(rtrn_type_o), 64'd0);
        checkOutput("reset_tid", 64'(rtrn_tid_o), 64'd0);
        checkOutput("reset_data", rtrn_data_o, 64'd0);
        checkOutput("reset_busy", 64'(busy_o), 64'd0);
        rst_i = 1'b0;
        #1;
        checkOutput("post_reset_rdy", 64'(req_rdy_o), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] basic store/load/atomic sequence");
        applyStimulus(RQ_STORE, 4'd3, 40'h08, 2'd3, 64'h1122334455667788, RT_ST_ACK, 64'h0, 1'b1, 1'b1);
        applyStimulus(RQ_LOAD, 4'd1, 40'h08, 2'd3, 64'h0, RT_LOAD, 64'h1122334455667788, 1'b1, 1'b0);
        applyStimulus(RQ_STORE, 4'd2, 40'h0A, 2'd0, 64'h0000_0000_00AB_0000, RT_ST_ACK, 64'h0, 1'b1, 1'b0);
        applyStimulus(RQ_LOAD, 4'd4, 40'h08, 2'd3, 64'h0, RT_LOAD, 64'h1122334455AB7788, 1'b1, 1'b0);
        applyStimulus(RQ_STORE, 4'd6, 40'h0C, 2'd2, 64'hDEADBEEF_00000000, RT_ST_ACK, 64'h0, 1'b1, 1'b0);
        applyStimulus(RQ_LOAD, 4'd7, 40'h08, 2'd3, 64'h0, RT_LOAD, 64'hDEADBEEF55AB7788, 1'b1, 1'b0);
        applyStimulus(RQ_ATOMIC, 4'd5, 40'h08, 2'd3, 64'hCAFE, RT_ATOMIC, 64'hDEADBEEF55AB7788, 1'b1, 1'b0);
        applyStimulus(RQ_LOAD, 4'd8, 40'h08, 2'd3, 64'h0, RT_LOAD, 64'h000000000000CAFE, 1'b1, 1'b0);
        applyStimulus(RQ_RSVD, 4'd9, 40'h08, 2'd3, 64'hFFFF, RT_ERR, 64'h0, 1'b1, 1'b0);
        applyStimulus(RQ_IMISS, 4'd10, 40'h08, 2'd3, 64'h0, RT_IFILL, 64'h000000000000CAFE, 1'b1, 1'b0);
        waitIdle();
        applyStimulus(RQ_INT, 4'd11, 40'h12_3456_789A, 2'd0, 64'h0, RT_INT, 64'h000000123456789A, 1'b1, 1'b1);

        $display("[TB] address wrap and partial-word stores");
        applyStimulus(RQ_STORE, 4'd12, 40'h208, 2'd3, 64'h55, RT_ST_ACK, 64'h0, 1'b1, 1'b0);
        applyStimulus(RQ_LOAD, 4'd13, 40'h08, 2'd3, 64'h0, RT_LOAD, 64'h55, 1'b1, 1'b0);
`ifdef L15_RTRN_ALIGN_CHK_EN
        applyStimulus(RQ_STORE, 4'd14, 40'h12, 2'd2, 64'h0000_AABB_CCDD_0000, RT_ERR, 64'h0, 1'b1, 1'b0);
        applyStimulus(RQ_LOAD, 4'd15, 40'h10, 2'd3, 64'h0, RT_LOAD, 64'h0, 1'b1, 1'b0);
        applyStimulus(RQ_STORE, 4'd1, 40'h1E, 2'd3, 64'h1122_0000_0000_0000, RT_ERR, 64'h0, 1'b1, 1'b0);
        applyStimulus(RQ_LOAD, 4'd2, 40'h18, 2'd3, 64'h0, RT_LOAD, 64'h0, 1'b1, 1'b0);
`else
        applyStimulus(RQ_STORE, 4'd14, 40'h12, 2'd2, 64'h0000_AABB_CCDD_0000, RT_ST_ACK, 64'h0, 1'b1, 1'b0);
        applyStimulus(RQ_LOAD, 4'd15, 40'h10, 2'd3, 64'h0, RT_LOAD, 64'h0000AABBCCDD0000, 1'b1, 1'b0);
        applyStimulus(RQ_STORE, 4'd1, 40'h1E, 2'd3, 64'h1122_0000_0000_0000, RT_ST_ACK, 64'h0, 1'b1, 1'b0);
        applyStimulus(RQ_LOAD, 4'd2, 40'h18, 2'd3, 64'h0, RT_LOAD, 64'h1122000000000000, 1'b1, 1'b0);
`endif
        waitIdle();

        $display("[TB] backpressure with ack held low");
        rtrn_ack_i = 1'b0;
        applyStimulus(RQ_LOAD, 4'd1, 40'h08, 2'd3, 64'h0, RT_LOAD, 64'h55, 1'b1, 1'b1);
        applyStimulus(RQ_LOAD, 4'd2, 40'h08, 2'd3, 64'h0, RT_LOAD, 64'h55, 1'b1, 1'b0);
        applyStimulus(RQ_LOAD, 4'd3, 40'h08, 2'd3, 64'h0, RT_LOAD, 64'h55, 1'b1, 1'b0);
        checkOutput("full_rdy", 64'(req_rdy_o), 64'd0);
        checkOutput("full_busy", 64'(busy_o), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("stall_val", 64'(rtrn_val_o), 64'd1);
        checkOutput("stall_tid", 64'(rtrn_tid_o), 64'd1);
        checkOutput("stall_rdy", 64'(req_rdy_o), 64'd0);
        rtrn_ack_i = 1'b1;
        waitIdle();
        checkOutput("drained_rdy", 64'(req_rdy_o), 64'd1);

        $display("[TB] reset during a pending load");
        applyStimulus(RQ_LOAD, 4'd9, 40'h08, 2'd3, 64'h0, RT_LOAD, 64'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_busy", 64'(busy_o), 64'd0);
        checkOutput("midrst_val", 64'(rtrn_val_o), 64'd0);
        checkOutput("midrst_rdy", 64'(req_rdy_o), 64'd0);
        rst_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(RQ_LOAD, 4'd10, 40'h08, 2'd3, 64'h0, RT_LOAD, 64'h0, 1'b1, 1'b1);
        applyStimulus(RQ_LOAD, 4'd11, 40'h18, 2'd3, 64'h0, RT_LOAD, 64'h0, 1'b1, 1'b0);
        waitIdle();
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/l15_rtrn_stub.md
Name: l15_rtrn_stub

Overview:
- Memory-side responder for the L1.5 request/return protocol. It stands in for the L1.5/L2 in standalone cache-subsystem simulation and FPGA builds without OpenPiton.
- Accepts requests issued by the cache adapter (L15_LOAD_RQ, L15_IMISS_RQ, L15_STORE_RQ, L15_ATOMIC_RQ, L15_INT_RQ) and executes them in order against a small internal word memory.
- Returns one packet per request with the matching return type and the echoed transaction ID.

Parameters:
- MEM_DEPTH, 64: number of 64-bit words in the backing memory; power of two, at least 2.
- REQ_FIFO_DEPTH, 2: request FIFO entries; power of two, at least 1.
- LATENCY, 2: extra wait cycles between FIFO pop and memory execution; 0 to 255.
- TID_WIDTH, wt_cache_pkg::L15_TID_WIDTH: transaction-ID width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_val_i  in  1  request valid
- req_rdy_o  out  1  request ready; equals !fifo_full
- req_rqtype_i  in  5  l15_reqtypes_t encoding
- req_tid_i  in  TID_WIDTH  transaction ID
- req_addr_i  in  40  byte address
- req_size_i  in  2  0=byte, 1=hword, 2=word, 3=dword (toSize64 encoding)
- req_data_i  in  64  store/atomic data, lane-aligned (byte k at [8k+:8])
- rtrn_val_o  out  1  return packet valid
- rtrn_ack_i  in  1  consumer accepts packet
- rtrn_type_o  out  4  l15_rtrntypes_t encoding
- rtrn_tid_o  out  TID_WIDTH  echoed transaction ID
- rtrn_data_o  out  64  return data
- busy_o  out  1  high when FIFO is non-empty or FSM is not IDLE

Behaviour:
- Request channel handshake:
  - A request is pushed when req_val_i && req_rdy_o.
  - The request fields are captured in the FIFO in the push cycle.
  - When the FIFO is full, req_rdy_o is 0 and no push occurs, even if the FSM pops in the same cycle; ready rises on the following cycle.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into an internal register, load cnt=LATENCY, go to WAIT.
  - WAIT: if cnt!=0, decrement and stay. If cnt==0, execute the memory operation, register the return fields, set rtrn_val_o=1, go to RESP.
  - RESP: hold all rtrn_* outputs stable until rtrn_ack_i. On ack, go to IDLE; rtrn_val_o drops the next cycle. There is no back-to-back pop in the ack cycle.
- Latency: with the FIFO empty and the FSM in IDLE, a request pushed in cycle t produces rtrn_val_o=1 at cycle t+3+LATENCY.
- Memory addressing:
  - Word index = req_addr_i[3 +: log2(MEM_DEPTH)]; upper address bits are ignored (wrap-around).
  - Byte offset = req_addr_i[2:0].
- Operation by request type:
  - LOAD: data = full 64-bit word; type L15_LOAD_RET.
  - IMISS: data = full word; type L15_IFILL_RET.
  - STORE: write the 1/2/4/8 bytes starting at the byte offset, clamped to the word end; data = 0; type L15_ST_ACK.
  - ATOMIC (swap): data = old word; write data bytes as for STORE; type L15_CPX_RESTYPE_ATOMIC_RES.
  - INT: no memory access; data = {24'h0, req_addr_i[39:0]}; type L15_INT_RET.
  - Any other rqtype: no memory access; data = 0; type L15_ERR_RET.
- Ordering: operations execute strictly in FIFO order. A store is visible to the next popped load.
- Reset:
  - Outputs: req_rdy_o=0 while rst_i is high, 1 afterwards; rtrn_val_o=0; rtrn_type_o=0; rtrn_tid_o=0; rtrn_data_o=0; busy_o=0.
  - State: FIFO emptied, FSM to IDLE, cnt=0, all memory words cleared to 0.
  - Reset asserted mid-operation drops any in-flight or pending packet, with no return.

Optional Feature:
- Macro: L15_RTRN_ALIGN_CHK_EN.
- Defined: a STORE or ATOMIC whose byte offset is not a multiple of its size (size 1 with addr[0]!=0; size 2 with addr[1:0]!=0; size 3 with addr[2:0]!=0) does not write memory. It returns type L15_ERR_RET with data 0, keeping the echoed TID, at the same latency.
- Undefined: no check; bytes are clamped at the word end as described above.

Test Plan:
- Reset, then STORE tid=3 addr=0x08 size=3 data=0x1122334455667788 -> ST_ACK tid=3 at t+5 (LATENCY=2). Then LOAD addr=0x08 -> LOAD_RET data 0x1122334455667788.
- STORE addr=0x0A size=0 data byte2=0xAB over the word above -> subsequent LOAD returns 0x1122334455AB7788. STORE addr=0x0C size=2 data=0xDEADBEEF_00000000 -> LOAD returns 0xDEADBEEF55AB7788.
- ATOMIC tid=5 addr=0x08 size=3 data=0xCAFE -> ATOMIC_RES with old word returned, then LOAD returns 0x000000000000CAFE. rqtype=5'b11111 -> ERR_RET with memory unchanged.
- Hold rtrn_ack_i=0 and push 3 requests (REQ_FIFO_DEPTH=2) -> req_rdy_o=0 after FIFO fills, outputs stable in RESP; release ack -> TIDs returned in order, ready reasserts.
- Assert rst_i during WAIT of a pending LOAD -> no return packet, busy_o=0 next cycle, LOAD of any address returns 0.
- With L15_RTRN_ALIGN_CHK_EN defined: STORE addr=0x0A size=2 -> ERR_RET, word unchanged. Without the macro: the same store writes bytes 2..5 and returns ST_ACK.
